// File: rtl/sram_bist_ctrl_if.sv
// SRAM-side bus owned by the BIST controller.
// Read data on dout is registered by the SRAM and is valid one cycle after the address.
`ifndef SRAM_ADDR_WIDTH
`define SRAM_ADDR_WIDTH 8
`endif
`ifndef SRAM_WORD_WIDTH
`define SRAM_WORD_WIDTH 4
`endif

interface sram_bist_ctrl_if #(
    parameter int ADDR_WIDTH = `SRAM_ADDR_WIDTH,
    parameter int WORD_WIDTH = `SRAM_WORD_WIDTH
) ();
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] din;
    logic                  we;
    logic [WORD_WIDTH-1:0] dout;

    modport master (output addr, output din, output we, input dout);
    modport slave  (input addr, input din, input we, output dout);
endinterface

// File: rtl/sram_bist_ctrl.sv
// March C- BIST controller for a single-port SRAM.
// It passes the functional port through when idle and captures the first miscompare.
`ifndef SRAM_ADDR_WIDTH
`define SRAM_ADDR_WIDTH 8
`endif
`ifndef SRAM_WORD_WIDTH
`define SRAM_WORD_WIDTH 4
`endif
`ifndef SRAM_DEPTH
`define SRAM_DEPTH 256
`endif

module sram_bist_ctrl #(
    parameter int ADDR_WIDTH = `SRAM_ADDR_WIDTH,
    parameter int WORD_WIDTH = `SRAM_WORD_WIDTH,
    parameter int DEPTH      = `SRAM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] func_addr,
    input  logic [WORD_WIDTH-1:0] func_din,
    input  logic                  func_we,
    sram_bist_ctrl_if.master      sram,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [2:0]            fail_elem,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [WORD_WIDTH-1:0] fail_data,
    output logic [7:0]            fail_count
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        M0    = 3'd1,
        M1    = 3'd2,
        M2    = 3'd3,
        M3    = 3'd4,
        M4    = 3'd5,
        M5    = 3'd6,
        DRAIN = 3'd7
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                  phase_reg, phase_next;
    logic                  chk_pending_reg, chk_pending_next;
    logic [WORD_WIDTH-1:0] chk_exp_reg, chk_exp_next;
    logic [2:0]            chk_elem_reg, chk_elem_next;
    logic [ADDR_WIDTH-1:0] chk_addr_reg, chk_addr_next;
    logic                  done_reg, done_next;
    logic                  fail_reg, fail_next;
    logic [2:0]            fail_elem_reg, fail_elem_next;
    logic [ADDR_WIDTH-1:0] fail_addr_reg, fail_addr_next;
    logic [WORD_WIDTH-1:0] fail_data_reg, fail_data_next;
    logic [7:0]            fail_count_reg, fail_count_next;

    // Element decode and per-cycle controls
    logic       elem_up;
    logic       elem_rd;
    logic       elem_wr;
    logic       rd_bg;
    logic       wr_bg;
    logic [2:0] elem_idx;
    logic       two_phase;
    logic       rd_cycle;
    logic       wr_cycle;
    logic       last_addr;
    logic [WORD_WIDTH-1:0] bist_din;
    logic [WORD_WIDTH-1:0] din_mux;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            phase_reg       <= 1'b0;
            chk_pending_reg <= 1'b0;
            chk_exp_reg     <= '0;
            chk_elem_reg    <= '0;
            chk_addr_reg    <= '0;
            done_reg        <= 1'b0;
            fail_reg        <= 1'b0;
            fail_elem_reg   <= '0;
            fail_addr_reg   <= '0;
            fail_data_reg   <= '0;
            fail_count_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            phase_reg       <= phase_next;
            chk_pending_reg <= chk_pending_next;
            chk_exp_reg     <= chk_exp_next;
            chk_elem_reg    <= chk_elem_next;
            chk_addr_reg    <= chk_addr_next;
            done_reg        <= done_next;
            fail_reg        <= fail_next;
            fail_elem_reg   <= fail_elem_next;
            fail_addr_reg   <= fail_addr_next;
            fail_data_reg   <= fail_data_next;
            fail_count_reg  <= fail_count_next;
        end
    end

    always_comb begin
        elem_up   = 1'b1;
        elem_rd   = 1'b0;
        elem_wr   = 1'b0;
        rd_bg     = 1'b0;
        wr_bg     = 1'b0;
        elem_idx  = 3'd0;
        unique case (state_reg)
            M0: begin elem_wr = 1'b1; end
            M1: begin elem_idx = 3'd1; elem_rd = 1'b1; elem_wr = 1'b1; wr_bg = 1'b1; end
            M2: begin elem_idx = 3'd2; elem_rd = 1'b1; elem_wr = 1'b1; rd_bg = 1'b1; end
            M3: begin elem_idx = 3'd3; elem_up = 1'b0; elem_rd = 1'b1; elem_wr = 1'b1; wr_bg = 1'b1; end
            M4: begin elem_idx = 3'd4; elem_up = 1'b0; elem_rd = 1'b1; elem_wr = 1'b1; rd_bg = 1'b1; end
            M5: begin elem_idx = 3'd5; elem_rd = 1'b1; end
            default: ;
        endcase

        // Read/write elements use phase 0 for the read and phase 1 for the write
        two_phase = elem_rd & elem_wr;
        rd_cycle  = elem_rd & (~two_phase | ~phase_reg);
        wr_cycle  = elem_wr & (~two_phase | phase_reg);
        last_addr = elem_up ? (addr_reg == ADDR_MAX) : (addr_reg == '0);
        bist_din  = (wr_cycle & wr_bg) ? '1 : '0;

        state_next       = state_reg;
        addr_next        = addr_reg;
        phase_next       = phase_reg;
        chk_pending_next = 1'b0;
        chk_exp_next     = chk_exp_reg;
        chk_elem_next    = chk_elem_reg;
        chk_addr_next    = chk_addr_reg;
        done_next        = done_reg;
        fail_next        = fail_reg;
        fail_elem_next   = fail_elem_reg;
        fail_addr_next   = fail_addr_reg;
        fail_data_next   = fail_data_reg;
        fail_count_next  = fail_count_reg;

        if (state_reg == IDLE) begin
            if (start) begin
                state_next      = M0;
                addr_next       = '0;
                phase_next      = 1'b0;
                done_next       = 1'b0;
                fail_next       = 1'b0;
                fail_elem_next  = '0;
                fail_addr_next  = '0;
                fail_data_next  = '0;
                fail_count_next = '0;
            end
        end else if (abort) begin
            // Abort wins over everything, including a compare due this cycle
            state_next = IDLE;
            phase_next = 1'b0;
        end else begin
            if (chk_pending_reg && (sram.dout != chk_exp_reg)) begin
                if (fail_count_reg != 8'hFF) begin
                    fail_count_next = fail_count_reg + 8'd1;
                end
                if (!fail_reg) begin
                    fail_next      = 1'b1;
                    fail_elem_next = chk_elem_reg;
                    fail_addr_next = chk_addr_reg;
                    fail_data_next = sram.dout;
                end
            end

            if (rd_cycle) begin
                chk_pending_next = 1'b1;
                chk_exp_next     = rd_bg ? '1 : '0;
                chk_elem_next    = elem_idx;
                chk_addr_next    = addr_reg;
            end

            if (state_reg == DRAIN) begin
                state_next = IDLE;
                done_next  = 1'b1;
            end else if (two_phase && !phase_reg) begin
                phase_next = 1'b1;
            end else begin
                phase_next = 1'b0;
                if (last_addr) begin
                    unique case (state_reg)
                        M0:      begin state_next = M1;    addr_next = '0;       end
                        M1:      begin state_next = M2;    addr_next = '0;       end
                        M2:      begin state_next = M3;    addr_next = ADDR_MAX; end
                        M3:      begin state_next = M4;    addr_next = ADDR_MAX; end
                        M4:      begin state_next = M5;    addr_next = '0;       end
                        M5:      begin state_next = DRAIN;                       end
                        default: begin state_next = IDLE;                        end
                    endcase
                end else begin
                    addr_next = elem_up ? (addr_reg + ADDR_WIDTH'(1)) : (addr_reg - ADDR_WIDTH'(1));
                end
            end
        end
    end

    assign busy = (state_reg != IDLE);

    // Functional path is combinational so it is live straight out of reset
    generate
        for (genvar gi = 0; gi < WORD_WIDTH; gi++) begin : g_din_mux
            assign din_mux[gi] = busy ? bist_din[gi] : func_din[gi];
        end
    endgenerate

    assign sram.addr = busy ? addr_reg : func_addr;
    assign sram.din  = din_mux;
    assign sram.we   = busy ? wr_cycle : func_we;

    assign done       = done_reg;
    assign fail       = fail_reg;
    assign fail_elem  = fail_elem_reg;
    assign fail_addr  = fail_addr_reg;
    assign fail_data  = fail_data_reg;
    assign fail_count = fail_count_reg;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Bench for sram_bist_ctrl: fault-injecting SRAM model, table vectors, corner sequences
// and random fault maps checked against an element-table March C- reference.
`timescale 1ns/1ps

module tb_sram_bist_ctrl;

    localparam int AW          = 8;
    localparam int WW          = 4;
    localparam int DEPTH       = 256;
    localparam int TEST_CYCLES = 10 * DEPTH + 1;
    localparam int LIMIT       = 3 * TEST_CYCLES;

    // March C- element table, bit e describes element Me
    localparam logic [5:0] EL_UP = 6'b100111;
    localparam logic [5:0] EL_RD = 6'b111110;
    localparam logic [5:0] EL_WR = 6'b011111;
    localparam logic [5:0] RD_BG = 6'b010100;
    localparam logic [5:0] WR_BG = 6'b001010;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] func_addr = '0;
    logic [WW-1:0] func_din = '0;
    logic          func_we = 1'b0;
    logic          busy, done, fail;
    logic [2:0]    fail_elem;
    logic [AW-1:0] fail_addr;
    logic [WW-1:0] fail_data;
    logic [7:0]    fail_count;

    sram_bist_ctrl_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) sif ();

    sram_bist_ctrl #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .func_addr  (func_addr),
        .func_din   (func_din),
        .func_we    (func_we),
        .sram       (sif),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_elem  (fail_elem),
        .fail_addr  (fail_addr),
        .fail_data  (fail_data),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    // SRAM model: registered read, faults override selected read bits
    logic [WW-1:0] mem   [DEPTH];
    logic [WW-1:0] fmask [DEPTH];
    logic [WW-1:0] fval  [DEPTH];
    logic [WW-1:0] dout_q;
    int            wr_cnt = 0;

    always @(posedge clk) begin
        if (sif.we) begin
            mem[sif.addr] <= sif.din;
            wr_cnt        <= wr_cnt + 1;
        end
        dout_q <= (mem[sif.addr] & ~fmask[sif.addr]) | (fval[sif.addr] & fmask[sif.addr]);
    end
    assign sif.dout = dout_q;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference results
    logic [WW-1:0] exp_mem [DEPTH];
    bit            m_fail;
    int            m_elem, m_addr, m_data, m_cnt;

    task automatic model_run();
        logic [5:0]    up_v, rd_v, wr_v, rbg_v, wbg_v;
        logic [WW-1:0] r, bg;
        int            a;
        up_v = EL_UP; rd_v = EL_RD; wr_v = EL_WR; rbg_v = RD_BG; wbg_v = WR_BG;
        m_fail = 0; m_elem = 0; m_addr = 0; m_data = 0; m_cnt = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < DEPTH; i++) begin
                a = up_v[e] ? i : DEPTH - 1 - i;
                if (rd_v[e]) begin
                    r  = (exp_mem[a] & ~fmask[a]) | (fval[a] & fmask[a]);
                    bg = {WW{rbg_v[e]}};
                    if (r != bg) begin
                        if (!m_fail) begin
                            m_fail = 1; m_elem = e; m_addr = a; m_data = int'(r);
                        end
                        if (m_cnt < 255) m_cnt++;
                    end
                end
                if (wr_v[e]) exp_mem[a] = {WW{wbg_v[e]}};
            end
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin
            fmask[i] = '0;
            fval[i]  = '0;
        end
    endtask

    // Starts a test and counts busy cycles; optional start re-pulse and abort
    task automatic run_test(input int restart_at, input int abort_at, output int cycles);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cycles = 0;
        while (busy && cycles < LIMIT) begin
            if (cycles == restart_at) start = 1'b1;
            else if (cycles == restart_at + 3) start = 1'b0;
            abort = (cycles == abort_at);
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic verify(input string tag, input int cycles, input bit e_fail, input int e_elem,
                          input int e_addr, input int e_data, input int e_cnt);
        int mism;
        $display("run %s: cycles=%0d done=%0d fail=%0d elem=%0d addr=%0d data=%0h count=%0d",
                 tag, cycles, done, fail, fail_elem, fail_addr, fail_data, fail_count);
        check({tag, " cycles"}, cycles, TEST_CYCLES);
        check({tag, " done"}, int'(done), 1);
        check({tag, " fail"}, int'(fail), int'(e_fail));
        check({tag, " fail_elem"}, int'(fail_elem), e_elem);
        check({tag, " fail_addr"}, int'(fail_addr), e_addr);
        check({tag, " fail_data"}, int'(fail_data), e_data);
        check({tag, " fail_count"}, int'(fail_count), e_cnt);
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) mism++;
        check({tag, " final_mem"}, mism, 0);
    endtask

    typedef struct {
        int faddr; int fmask; int fval;
        bit e_fail; int e_elem; int e_addr; int e_data; int e_cnt;
    } vec_t;
    vec_t vecs [5];

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, w0, nz, n, a;

        vecs[0] = '{0,   0,  0,  1'b0, 0, 0,   0,  0};
        vecs[1] = '{10,  15, 3,  1'b1, 1, 10,  3,  5};
        vecs[2] = '{255, 4,  4,  1'b1, 1, 255, 4,  3};
        vecs[3] = '{0,   1,  0,  1'b1, 2, 0,   14, 2};
        vecs[4] = '{128, 15, 15, 1'b1, 1, 128, 15, 3};

        clear_faults();

        // Reset state and combinational passthrough
        func_addr = 8'h11; func_din = 4'h6; func_we = 1'b0;
        repeat (3) @(negedge clk);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst fail", int'(fail), 0);
        check("rst fail_count", int'(fail_count), 0);
        check("rst fail_addr", int'(fail_addr), 0);
        check("rst sram_addr", int'(sif.addr), 'h11);
        check("rst sram_din", int'(sif.din), 'h6);
        check("rst sram_we", int'(sif.we), 0);
        rst_n = 1'b1;

        // Idle passthrough write
        @(negedge clk); func_we = 1'b1; func_addr = 8'h20; func_din = 4'hA;
        #1 check("idle sram_we", int'(sif.we), 1);
        @(negedge clk); func_we = 1'b0;
        check("idle write mem", int'(mem[8'h20]), 'hA);
        $display("idle write: addr=20 data=%0h", mem[8'h20]);

        // Table vectors
        for (int v = 0; v < 5; v++) begin
            clear_faults();
            fmask[vecs[v].faddr] = WW'(vecs[v].fmask);
            fval[vecs[v].faddr]  = WW'(vecs[v].fval);
            model_run();
            run_test(-1, -1, cyc);
            verify($sformatf("vec%0d", v), cyc, vecs[v].e_fail, vecs[v].e_elem,
                   vecs[v].e_addr, vecs[v].e_data, vecs[v].e_cnt);
            if (v == 0) begin
                nz = 0;
                for (int i = 0; i < DEPTH; i++) if (mem[i] != '0) nz++;
                check("vec0 words nonzero", nz, 0);
            end
        end

        // start while busy is ignored
        clear_faults();
        model_run();
        run_test(50, -1, cyc);
        verify("restart_ignored", cyc, 0, 0, 0, 0, 0);

        // Abort 100 cycles after start, then a full rerun
        run_test(-1, 100, cyc);
        w0 = wr_cnt;
        $display("abort: busy_cycles=%0d busy=%0d done=%0d", cyc, busy, done);
        check("abort busy_cycles", cyc, 101);
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort sram_we", int'(sif.we), 0);
        repeat (5) @(negedge clk);
        check("abort no writes", wr_cnt - w0, 0);
        check("abort busy stays low", int'(busy), 0);
        model_run();
        run_test(-1, -1, cyc);
        verify("after_abort", cyc, 0, 0, 0, 0, 0);

        // Reset pulsed in the middle of M3
        clear_faults();
        fmask[10] = 4'hF; fval[10] = 4'h3;
        func_addr = 8'h5A; func_din = 4'h9; func_we = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (busy && n < 1400) begin n++; @(negedge clk); end
        check("midrst reached M3", n, 1400);
        check("midrst fail before reset", int'(fail), 1);
        #2 rst_n = 1'b0;
        #1;
        $display("mid-test reset: busy=%0d fail=%0d count=%0d sram_addr=%0h", busy, fail, fail_count, sif.addr);
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        check("midrst fail", int'(fail), 0);
        check("midrst fail_count", int'(fail_count), 0);
        check("midrst fail_elem", int'(fail_elem), 0);
        check("midrst fail_data", int'(fail_data), 0);
        check("midrst sram_addr", int'(sif.addr), 'h5A);
        check("midrst sram_din", int'(sif.din), 'h9);
        check("midrst sram_we", int'(sif.we), 0);
        w0 = wr_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst no writes", wr_cnt - w0, 0);
        check("midrst busy after release", int'(busy), 0);
        func_we = 1'b1; func_addr = 8'h30; func_din = 4'h7;
        @(negedge clk); func_we = 1'b0;
        check("midrst func write mem", int'(mem[8'h30]), 7);
        check("midrst func write count", wr_cnt - w0, 1);

        // Random fault maps against the reference
        for (int r = 0; r < 4; r++) begin
            clear_faults();
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                a = $urandom_range(0, DEPTH - 1);
                fmask[a] = WW'($urandom_range(1, 15));
                fval[a]  = WW'($urandom_range(0, 15));
            end
            model_run();
            run_test(-1, -1, cyc);
            verify($sformatf("rand%0d", r), cyc, m_fail, m_elem, m_addr, m_data, m_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_bist_ctrl.md
# sram_bist_ctrl

March C- built-in self-test controller for the 256x4b single-port SRAM. Sequences all SRAM writes and reads during a test, compares each read word against its expected background, and captures the first failure. Outside a test it passes the functional port straight through to the SRAM. It sits between the functional logic and the SRAM instance and owns the SRAM's address, data-in and write-enable.

## Interface
- ADDR_WIDTH, `SRAM_ADDR_WIDTH (8), SRAM address width
- WORD_WIDTH, `SRAM_WORD_WIDTH (4), SRAM word width
- DEPTH, `SRAM_DEPTH (256), number of words; equals 2**ADDR_WIDTH
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level; sampled only in IDLE
- abort  in  1  level; ends a running test
- func_addr / func_din / func_we  in  ADDR_WIDTH / WORD_WIDTH / 1  functional port
- sram_addr / sram_din / sram_we  out  ADDR_WIDTH / WORD_WIDTH / 1  to SRAM
- sram_dout  in  WORD_WIDTH  SRAM read data; valid the cycle after its address is presented
- busy  out  1  test running
- done  out  1  sticky; test completed without abort
- fail  out  1  sticky; at least one miscompare
- fail_elem  out  3  March element index of first miscompare
- fail_addr  out  ADDR_WIDTH  address of first miscompare
- fail_data  out  WORD_WIDTH  read word of first miscompare
- fail_count  out  8  miscompare count, saturates at 255

## Operation
- States: IDLE, M0..M5, DRAIN.
- Elements, with 0 = all-zeros and 1 = all-ones:
  - M0 up (w0)
  - M1 up (r0, w1)
  - M2 up (r1, w0)
  - M3 down (r0, w1)
  - M4 down (r1, w0)
  - M5 up (r0)
- Up elements run from address 0 to DEPTH-1. Down elements run from DEPTH-1 to 0.
- At an element's last address, go straight to the next element with no idle cycle. The counter reloads to 0 for up elements and DEPTH-1 for down elements.
- M1..M4 spend two cycles per address, read then write, at the same address. M0 and M5 spend one cycle per address.
- Read check: every read cycle sets a check-pending flag together with the expected value, element index and address. In the following cycle sram_dout is compared against the expected value.
- DRAIN: one cycle after M5 that performs the final compare. It then moves to IDLE, sets done and clears busy.
- On miscompare:
  - fail_count increments, saturating at 255.
  - If fail is 0: set fail and load fail_elem, fail_addr and fail_data.
  - The test always runs to completion.
- Start in IDLE (start=1):
  - Clear done, fail, fail_* and fail_count.
  - Set busy and enter M0 at address 0.
- start while busy is ignored.
- abort while busy:
  - Next state is IDLE, busy clears, done stays 0.
  - fail and fail_* keep their values.
  - Any pending check is discarded.
- abort has priority over the last-address transition.
- SRAM mux:
  - busy=0: sram_* = func_*, combinational.
  - busy=1: sram_* come from the controller. func_we is ignored and never reaches the SRAM.
- Reset:
  - busy, done, fail, fail_elem, fail_addr, fail_data and fail_count go to 0; state goes to IDLE.
  - sram_* immediately follow func_*.
  - Reset in the middle of a test ends it the same way, with no further SRAM writes.

## Timing
- Start is sampled at edge k. busy=1 after edge k, and the first M0 write is driven in cycle k+1.
- The test lasts 10*DEPTH + 1 cycles: DEPTH + 4*2*DEPTH + DEPTH + 1 drain cycle. That is 2561 cycles for DEPTH=256.
- At the end of DRAIN, done goes to 1 and busy goes to 0 on the same edge.
- Read-to-compare latency is 1 cycle.
- In M1..M4 the compare happens in the write cycle at the same address. This is legal because the SRAM registers the address and updates the array only at the end of that cycle.
- fail and fail_* update on the edge that ends the compare cycle.
- sram_we=1 only in write cycles, with sram_din set to the element's write background.

## Test plan
- Fault-free SRAM model, start pulse:
  - busy is high for exactly 2561 cycles, then done=1, fail=0, fail_count=0.
  - Every SRAM word ends at 4'h0.
- SRAM model that always returns 4'h3 at address 10, start:
  - done=1, fail=1, fail_elem=1, fail_addr=10, fail_data=4'h3.
  - fail_count=5, one per read element.
- Stuck bit: bit 2 at address 255 forced to 1:
  - First failure is elem=1, addr=255, data=4'h4.
  - fail_count=3, from the r0 reads in M1, M3 and M5.
- abort asserted 100 cycles after start:
  - busy drops the next cycle, done=0, no SRAM write after the abort edge.
  - A new start then runs a full 2561-cycle test.
- rst_n pulsed low in the middle of M3:
  - All outputs go to 0 immediately, and sram_* track func_*.
  - The SRAM is written only through func_we afterwards.
- Idle passthrough: func_we=1, func_addr=8'h20, func_din=4'hA:
  - The SRAM is written.
  - start pulsed while busy=1 does not restart the test and does not change its cycle count.
